// File: rtl/ctrl_decode_stage.sv
// Registered instruction decode stage: valid/ready output register, multiply stall/writeback sequencing, flush.
// Define CTRL_FLOP_EN to decode class 5 as ALU ops 15+sub; when undefined, class 5 is a no-op flagged illegal.
module ctrl_decode_stage #(
  parameter int IR_W    = 32,
  parameter int ALU_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  ir,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             i_r,
  output logic             write_reg_en,
  output logic             regfile_src_oalu_st,
  output logic [ALU_W-1:0] alu_inst,
  output logic             jump,
  output logic             br_inst,
  output logic             wr_en_stk,
  output logic             illegal,
  output logic             mul_wb,
  output logic             busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_mul_wb;
  logic             w_mul_wb_next;

  logic             r_out_valid;
  logic             r_i_r;
  logic             r_wr;
  logic             r_src;
  logic [ALU_W-1:0] r_alu;
  logic             r_jump;
  logic             r_br;
  logic             r_stk;
  logic             r_illegal;

  logic [2:0]       w_class;
  logic [1:0]       w_sub;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_unused_ir;

  logic             w_dec_i_r;
  logic             w_dec_wr;
  logic             w_dec_src;
  logic [ALU_W-1:0] w_dec_alu;
  logic             w_dec_jump;
  logic             w_dec_br;
  logic             w_dec_stk;
  logic             w_dec_ill;

  assign w_class     = ir[IR_W-1:IR_W-3];
  assign w_sub       = ir[IR_W-4:IR_W-5];
  assign w_unused_ir = ^ir[IR_W-6:0];

  assign w_in_ready = rst_n & ~flush & (r_state == RUN) & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_is_mul   = (w_class == 3'd0) && (w_sub == 2'd3);

  always_comb begin
    w_dec_i_r  = 1'b0;
    w_dec_wr   = 1'b0;
    w_dec_src  = 1'b0;
    w_dec_alu  = '0;
    w_dec_jump = 1'b0;
    w_dec_br   = 1'b0;
    w_dec_stk  = 1'b0;
    w_dec_ill  = 1'b0;
    case (w_class)
      3'd0: begin
        w_dec_i_r = (w_sub != 2'd1);
        w_dec_wr  = (w_sub != 2'd3);
        case (w_sub)
          2'd2:    w_dec_alu = ALU_W'(1);
          2'd3:    w_dec_alu = ALU_W'(6);
          default: w_dec_alu = '0;
        endcase
      end
      3'd1: begin
        case (w_sub)
          2'd0: begin
            w_dec_src = 1'b1;
            w_dec_wr  = 1'b1;
          end
          2'd1:    w_dec_stk = 1'b1;
          2'd2:    w_dec_wr  = 1'b1;
          default: begin
            w_dec_alu = ALU_W'(2);
            w_dec_i_r = 1'b1;
            w_dec_wr  = 1'b1;
          end
        endcase
      end
      3'd2: begin
        w_dec_br  = 1'b1;
        w_dec_i_r = 1'b1;
        case (w_sub)
          2'd0:    w_dec_alu = ALU_W'(12);
          2'd1:    w_dec_alu = ALU_W'(13);
          2'd2:    w_dec_alu = ALU_W'(11);
          default: w_dec_alu = ALU_W'(14);
        endcase
      end
      3'd3: w_dec_jump = 1'b1;
      3'd4: begin
        w_dec_wr  = 1'b1;
        w_dec_i_r = (w_sub == 2'd0) || (w_sub == 2'd3);
        case (w_sub)
          2'd0, 2'd1: w_dec_alu = ALU_W'(11);
          2'd2:       w_dec_alu = ALU_W'(12);
          default:    w_dec_alu = ALU_W'(3);
        endcase
      end
      3'd5: begin
`ifdef CTRL_FLOP_EN
        w_dec_alu = ALU_W'(15 + int'(w_sub));
        w_dec_i_r = 1'b1;
        w_dec_wr  = 1'b1;
`else
        w_dec_ill = 1'b1;
`endif
      end
      3'd6: begin
        w_dec_wr  = 1'b1;
        w_dec_alu = w_sub[0] ? ALU_W'(5) : ALU_W'(4);
        w_dec_i_r = ~w_sub[1];
      end
      default: begin
        w_dec_wr  = 1'b1;
        w_dec_alu = ALU_W'(7 + int'(w_sub));
      end
    endcase
  end

  // Multiply sequencing: stall intake until the counter expires, then strobe writeback once.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mul_wb_next = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept && w_is_mul) begin
          w_state_next = MUL_WAIT;
          w_cnt_next   = CNT_W'(MUL_LAT - 1);
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next  = RUN;
          w_mul_wb_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_mul_wb <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mul_wb <= w_mul_wb_next;
    end
  end

  // Decoded fields are cleared whenever the word stops being valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_i_r       <= 1'b0;
      r_wr        <= 1'b0;
      r_src       <= 1'b0;
      r_alu       <= '0;
      r_jump      <= 1'b0;
      r_br        <= 1'b0;
      r_stk       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_i_r       <= w_dec_i_r;
      r_wr        <= w_dec_wr;
      r_src       <= w_dec_src;
      r_alu       <= w_dec_alu;
      r_jump      <= w_dec_jump;
      r_br        <= w_dec_br;
      r_stk       <= w_dec_stk;
      r_illegal   <= w_dec_ill;
    end else if (flush || (r_out_valid && out_ready)) begin
      r_out_valid <= 1'b0;
      r_i_r       <= 1'b0;
      r_wr        <= 1'b0;
      r_src       <= 1'b0;
      r_alu       <= '0;
      r_jump      <= 1'b0;
      r_br        <= 1'b0;
      r_stk       <= 1'b0;
      r_illegal   <= 1'b0;
    end
  end

  assign in_ready            = w_in_ready;
  assign out_valid           = r_out_valid;
  assign i_r                 = r_i_r;
  assign write_reg_en        = r_wr;
  assign regfile_src_oalu_st = r_src;
  assign alu_inst            = r_alu;
  assign jump                = r_jump;
  assign br_inst             = r_br;
  assign wr_en_stk           = r_stk;
  assign illegal             = r_illegal;
  assign mul_wb              = r_mul_wb;
  assign busy                = (r_state == MUL_WAIT);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Randomised and directed bench for ctrl_decode_stage against a table-driven opcode model
// plus a cycle-level handshake/multiply model.
module tb_ctrl_decode_stage;

  localparam int MUL_LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        i_r;
  logic        write_reg_en;
  logic        regfile_src_oalu_st;
  logic [3:0]  alu_inst;
  logic        jump;
  logic        br_inst;
  logic        wr_en_stk;
  logic        illegal;
  logic        mul_wb;
  logic        busy;

  ctrl_decode_stage #(.IR_W(32), .ALU_W(4), .MUL_LAT(MUL_LAT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .ir                  (ir),
    .flush               (flush),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .i_r                 (i_r),
    .write_reg_en        (write_reg_en),
    .regfile_src_oalu_st (regfile_src_oalu_st),
    .alu_inst            (alu_inst),
    .jump                (jump),
    .br_inst             (br_inst),
    .wr_en_stk           (wr_en_stk),
    .illegal             (illegal),
    .mul_wb              (mul_wb),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       irr;
    logic       wr;
    logic       src;
    logic       stk;
    logic       br;
    logic       jmp;
    logic       ill;
  } dec_t;

  dec_t ref_tab [32];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid  = 1'b0;
  dec_t m_word;
  int   m_cnt    = 0;
  logic m_wb     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dec_t mk(input int alu, input bit irr, input bit wr, input bit src,
                              input bit stk, input bit br, input bit jmp, input bit ill);
    dec_t d;
    d.alu = 4'(alu);
    d.irr = irr; d.wr = wr; d.src = src; d.stk = stk;
    d.br = br; d.jmp = jmp; d.ill = ill;
    return d;
  endfunction

  // Opcode table indexed by {class, sub}.
  task automatic build_table();
    int br_alu [4] = '{12, 13, 11, 14};
    ref_tab[0] = mk(0, 1, 1, 0, 0, 0, 0, 0);
    ref_tab[1] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    ref_tab[2] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    ref_tab[3] = mk(6, 1, 0, 0, 0, 0, 0, 0);
    ref_tab[4] = mk(0, 0, 1, 1, 0, 0, 0, 0);
    ref_tab[5] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    ref_tab[6] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    ref_tab[7] = mk(2, 1, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      ref_tab[8 + s]  = mk(br_alu[s], 1, 0, 0, 0, 1, 0, 0);
      ref_tab[12 + s] = mk(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef CTRL_FLOP_EN
      ref_tab[20 + s] = mk((15 + s) % 16, 1, 1, 0, 0, 0, 0, 0);
`else
      ref_tab[20 + s] = mk(0, 0, 0, 0, 0, 0, 0, 1);
`endif
      ref_tab[24 + s] = mk((s % 2 == 0) ? 4 : 5, s < 2, 1, 0, 0, 0, 0, 0);
      ref_tab[28 + s] = mk(7 + s, 0, 1, 0, 0, 0, 0, 0);
    end
    ref_tab[16] = mk(11, 1, 1, 0, 0, 0, 0, 0);
    ref_tab[17] = mk(11, 0, 1, 0, 0, 0, 0, 0);
    ref_tab[18] = mk(12, 0, 1, 0, 0, 0, 0, 0);
    ref_tab[19] = mk(3,  1, 1, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: drive, check in_ready, advance the model, check registered outputs.
  task automatic step(input logic iv, input logic [31:0] irv, input logic fl, input logic ordy);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    in_valid  = iv;
    ir        = irv;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_rdy = !fl && (m_cnt == 0) && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc  = iv && exp_rdy;
    m_wb = 1'b0;
    if (m_cnt > 0) begin
      if (fl) m_cnt = 0;
      else begin
        m_cnt--;
        if (m_cnt == 0) m_wb = 1'b1;
      end
    end
    if (acc && irv[31:27] == 5'd3) m_cnt = MUL_LAT;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_word  = ref_tab[irv[31:27]];
    end else if (m_valid && ordy) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_cnt > 0));
    check("mul_wb", 32'(mul_wb), 32'(m_wb));
    if (m_valid) begin
      check("alu_inst", 32'(alu_inst), 32'(m_word.alu));
      check("i_r", 32'(i_r), 32'(m_word.irr));
      check("write_reg_en", 32'(write_reg_en), 32'(m_word.wr));
      check("regfile_src", 32'(regfile_src_oalu_st), 32'(m_word.src));
      check("wr_en_stk", 32'(wr_en_stk), 32'(m_word.stk));
      check("br_inst", 32'(br_inst), 32'(m_word.br));
      check("jump", 32'(jump), 32'(m_word.jmp));
      check("illegal", 32'(illegal), 32'(m_word.ill));
    end else begin
      check("illegal_idle", 32'(illegal), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mul_wb"}, 32'(mul_wb), 32'd0);
    check({tag, "_alu"}, 32'(alu_inst), 32'd0);
    check({tag, "_flags"}, 32'({i_r, write_reg_en, regfile_src_oalu_st, jump, br_inst, wr_en_stk, illegal}), 32'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    build_table();
    rst_n = 1'b1; in_valid = 1'b0; ir = '0; flush = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back add then nor
    step(1, 32'h0000_0000, 0, 1);
    check("bb_add_alu", 32'(alu_inst), 32'd0);
    step(1, 32'hC800_0000, 0, 1);
    check("bb_nor_alu", 32'(alu_inst), 32'd5);
    step(0, 32'h0, 0, 1);

    // backpressure holds the word and blocks intake
    step(1, 32'h3800_0000, 0, 0);
    step(1, 32'hC800_0000, 0, 0);
    check("bp_hold_alu", 32'(alu_inst), 32'd2);
    step(1, 32'hC800_0000, 0, 1);
    check("bp_next_alu", 32'(alu_inst), 32'd5);
    step(0, 32'h0, 0, 1);

    // multiply: three stalled cycles then one writeback strobe
    step(1, 32'h1800_0000, 0, 1);
    check("mul_alu", 32'(alu_inst), 32'd6);
    check("mul_busy", 32'(busy), 32'd1);
    step(1, 32'h0000_0000, 0, 1);
    step(1, 32'h0000_0000, 0, 1);
    step(0, 32'h0000_0000, 0, 1);
    check("mul_wb_pulse", 32'(mul_wb), 32'd1);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);

    // flush during the multiply wait with a competing instruction
    step(1, 32'h1800_0000, 0, 1);
    step(1, 32'h0000_0000, 1, 1);
    check("flush_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) step(0, 32'h0, 0, 1);

    // class 5 option
    step(1, 32'hA800_0000, 0, 1);
`ifdef CTRL_FLOP_EN
    check("c5_illegal", 32'(illegal), 32'd0);
    check("c5_wr", 32'(write_reg_en), 32'd1);
`else
    check("c5_illegal", 32'(illegal), 32'd1);
    check("c5_wr", 32'(write_reg_en), 32'd0);
`endif
    step(0, 32'h0, 1, 1);

    // reset in the middle of a multiply wait
    step(1, 32'h1800_0000, 0, 0);
    step(0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    m_valid = 1'b0; m_cnt = 0; m_wb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(0, 32'h0, 0, 1);

    // randomised traffic
    for (int n = 0; n < 2000; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 5) == 0) rnd[31:27] = 5'd3;
      step($urandom_range(0, 9) < 7, rnd, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
